// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the asteroid game scheduler.
//   - game state encoding and width
//   - BCD digit width
//   - default divider / frame parameters for the 50 MHz DE2 board clock
//   - bcd_digit_inc: single BCD digit increment with carry in/out
package game_pkg;

  localparam int STATE_W = 2;
  localparam int DIGIT_W = 4;

  localparam int FRAME_DIV_DEF      = 1666667;
  localparam int FRAMES_PER_SEC_DEF = 30;
  localparam int SPAWN_FRAMES_DEF   = 42;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Returns {carry_out, next_digit}; digit 9 with carry_in rolls to 0.
  function automatic logic [DIGIT_W:0] bcd_digit_inc(input logic [DIGIT_W-1:0] digit,
                                                     input logic               carry_in);
    logic [DIGIT_W:0] result;
    if (!carry_in) begin
      result = {1'b0, digit};
    end else if (digit == 4'd9) begin
      result = {1'b1, 4'd0};
    end else begin
      result = {1'b0, digit + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd4_counter.sv
// bcd4_counter: four-digit BCD up counter for the elapsed-time display.
//   clock  board clock
//   reset  asynchronous, active-high
//   clear  synchronous clear to 0000 (wins over inc)
//   inc    add one second on this edge
//   dig0..dig3  BCD digits, dig0 = ones
// Build option: TIMER_SATURATE_EN -- when defined the count holds at 9999,
// otherwise 9999 wraps to 0000.
module bcd4_counter
  import game_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] dig0,
  output logic [DIGIT_W-1:0] dig1,
  output logic [DIGIT_W-1:0] dig2,
  output logic [DIGIT_W-1:0] dig3
);

  logic [4*DIGIT_W-1:0] digits_r;
  logic [4*DIGIT_W-1:0] digits_next_s;
  logic [DIGIT_W:0]     s0_s, s1_s, s2_s, s3_s;
  logic                 rollover_s;

  // Ripple the carry through all four digits and decide the 9999 behaviour.
  always_comb begin
    s0_s = bcd_digit_inc(digits_r[DIGIT_W-1:0],           inc);
    s1_s = bcd_digit_inc(digits_r[2*DIGIT_W-1:DIGIT_W],   s0_s[DIGIT_W]);
    s2_s = bcd_digit_inc(digits_r[3*DIGIT_W-1:2*DIGIT_W], s1_s[DIGIT_W]);
    s3_s = bcd_digit_inc(digits_r[4*DIGIT_W-1:3*DIGIT_W], s2_s[DIGIT_W]);
    // Carry out of the top digit only happens on 9999 + 1.
    rollover_s = s3_s[DIGIT_W];
`ifdef TIMER_SATURATE_EN
    if (rollover_s) begin
      digits_next_s = digits_r;
    end else begin
      digits_next_s = {s3_s[DIGIT_W-1:0], s2_s[DIGIT_W-1:0], s1_s[DIGIT_W-1:0], s0_s[DIGIT_W-1:0]};
    end
`else
    if (rollover_s) begin
      digits_next_s = '0;
    end else begin
      digits_next_s = {s3_s[DIGIT_W-1:0], s2_s[DIGIT_W-1:0], s1_s[DIGIT_W-1:0], s0_s[DIGIT_W-1:0]};
    end
`endif
  end

  // Digit register with clear for a new game.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_r <= '0;
    end else if (clear) begin
      digits_r <= '0;
    end else begin
      digits_r <= digits_next_s;
    end
  end

  assign dig0 = digits_r[DIGIT_W-1:0];
  assign dig1 = digits_r[2*DIGIT_W-1:DIGIT_W];
  assign dig2 = digits_r[3*DIGIT_W-1:2*DIGIT_W];
  assign dig3 = digits_r[4*DIGIT_W-1:3*DIGIT_W];

endmodule

// File: rtl/game_tick_controller.sv
// game_tick_controller: game state machine and tick scheduler.
//   clock       board clock (CLOCK_50)
//   reset       asynchronous, active-high
//   start       pulse: new game from IDLE or OVER
//   pause       pulse: toggle RUN <-> PAUSE
//   collision   pulse: ship hit, RUN -> OVER
//   state       0=IDLE 1=RUN 2=PAUSE 3=OVER
//   frame_tick  one pulse per frame (FRAME_DIV clocks)
//   spawn_tick  one pulse every SPAWN_FRAMES frames
//   sec_tick    one pulse every FRAMES_PER_SEC frames
//   dig0..dig3  BCD elapsed seconds, dig0 = ones
// Build option: TIMER_SATURATE_EN (see bcd4_counter) holds the timer at 9999.
module game_tick_controller
  import game_pkg::*;
#(
  parameter int FRAME_DIV      = FRAME_DIV_DEF,
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int SPAWN_FRAMES   = SPAWN_FRAMES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               collision,
  output logic [STATE_W-1:0] state,
  output logic               frame_tick,
  output logic               spawn_tick,
  output logic               sec_tick,
  output logic [DIGIT_W-1:0] dig0,
  output logic [DIGIT_W-1:0] dig1,
  output logic [DIGIT_W-1:0] dig2,
  output logic [DIGIT_W-1:0] dig3
);

  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam int FRM_W = $clog2(FRAMES_PER_SEC);
  localparam int SPN_W = $clog2(SPAWN_FRAMES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_SEC - 1);
  localparam logic [SPN_W-1:0] SPN_LAST = SPN_W'(SPAWN_FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
  localparam logic [SPN_W-1:0] SPN_ONE  = SPN_W'(1);

  game_state_e       state_r, state_next_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [FRM_W-1:0]  frame_cnt_r;
  logic [SPN_W-1:0]  spawn_cnt_r;
  logic              frame_tick_r, sec_tick_r, spawn_tick_r;
  logic              new_game_s, advance_s;
  logic              frame_evt_s, sec_evt_s, spawn_evt_s;

  // Next-state logic; collision outranks pause, pause outranks start.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (collision)  state_next_s = ST_OVER;
        else if (pause) state_next_s = ST_PAUSE;
        else            state_next_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (pause) state_next_s = ST_RUN;
        else       state_next_s = ST_PAUSE;
      end
      ST_OVER: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_OVER;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Counters advance only on cycles that stay in RUN, so a pause or
  // collision landing on the divider's last count freezes it and drops the tick.
  always_comb begin
    new_game_s  = 1'b0;
    advance_s   = 1'b0;
    frame_evt_s = 1'b0;
    sec_evt_s   = 1'b0;
    spawn_evt_s = 1'b0;
    if ((state_r == ST_IDLE || state_r == ST_OVER) && state_next_s == ST_RUN) begin
      new_game_s = 1'b1;
    end else begin
      new_game_s = 1'b0;
    end
    if (state_r == ST_RUN && state_next_s == ST_RUN) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
    if (advance_s && div_cnt_r == DIV_LAST) begin
      frame_evt_s = 1'b1;
      sec_evt_s   = (frame_cnt_r == FRM_LAST);
      spawn_evt_s = (spawn_cnt_r == SPN_LAST);
    end else begin
      frame_evt_s = 1'b0;
      sec_evt_s   = 1'b0;
      spawn_evt_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Clock divider and frame/spawn counters; a new game restarts them all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_r   <= '0;
      frame_cnt_r <= '0;
      spawn_cnt_r <= '0;
    end else if (new_game_s) begin
      div_cnt_r   <= '0;
      frame_cnt_r <= '0;
      spawn_cnt_r <= '0;
    end else if (frame_evt_s) begin
      div_cnt_r   <= '0;
      frame_cnt_r <= sec_evt_s   ? '0 : frame_cnt_r + FRM_ONE;
      spawn_cnt_r <= spawn_evt_s ? '0 : spawn_cnt_r + SPN_ONE;
    end else if (advance_s) begin
      div_cnt_r   <= div_cnt_r + DIV_ONE;
    end else begin
      div_cnt_r   <= div_cnt_r;
    end
  end

  // Registered single-cycle tick pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_tick_r <= 1'b0;
      sec_tick_r   <= 1'b0;
      spawn_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= frame_evt_s;
      sec_tick_r   <= sec_evt_s;
      spawn_tick_r <= spawn_evt_s;
    end
  end

  // Elapsed-time digits step on the same edge that raises sec_tick.
  bcd4_counter u_timer (
    .clock (clock),
    .reset (reset),
    .clear (new_game_s),
    .inc   (sec_evt_s),
    .dig0  (dig0),
    .dig1  (dig1),
    .dig2  (dig2),
    .dig3  (dig3)
  );

  assign state      = state_r;
  assign frame_tick = frame_tick_r;
  assign sec_tick   = sec_tick_r;
  assign spawn_tick = spawn_tick_r;

endmodule

// File: doc/game_tick_controller.md
Name: game_tick_controller

Overview:
Central game scheduler for the asteroid game on the DE2.
- Owns the game state machine: idle, running, paused, game over.
- Divides the 50 MHz board clock into frame, asteroid-spawn and one-second ticks; all of these advance only while the game is running.
- Keeps the 4-digit BCD elapsed-time count that drives the HEX timer display.
- Game logic, asteroid spawner and HEX drivers consume its single-cycle tick pulses and state outputs.

Parameters:
FRAME_DIV, 1666667, board clocks per frame (50 MHz / 30 Hz); divider counts 0..FRAME_DIV-1
FRAMES_PER_SEC, 30, frames per elapsed-time second
SPAWN_FRAMES, 42, frames between asteroid spawn ticks (about 1.4 s)

Ports:
clock  in  1  board clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts a new game from IDLE or OVER
pause  in  1  one-cycle pulse; toggles RUN and PAUSE
collision  in  1  one-cycle pulse; ship hit, ends the game
state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER
frame_tick  out  1  one-cycle pulse per frame
spawn_tick  out  1  one-cycle pulse every SPAWN_FRAMES frames
sec_tick  out  1  one-cycle pulse every FRAMES_PER_SEC frames
dig0..dig3  out  4 each  BCD elapsed seconds; dig0 = ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE; all ticks 0; dig0..dig3=0; div_cnt, frame_cnt and spawn_cnt = 0.
- All outputs are registered.
- FSM transitions, evaluated each clock:
  - IDLE: start -> RUN.
  - RUN: collision -> OVER; else pause -> PAUSE.
  - PAUSE: pause -> RUN; start and collision ignored.
  - OVER: start -> RUN.
- Priority within one cycle: collision > pause > start.
- Entering RUN from IDLE or OVER clears div_cnt, frame_cnt, spawn_cnt and dig0..dig3 in that same clock edge.
- Entering RUN from PAUSE resumes all counters unchanged.
- Divider:
  - Increments only in RUN; holds in IDLE, PAUSE and OVER.
  - At FRAME_DIV-1 it wraps to 0. That same edge sets frame_tick=1 for exactly one cycle.
  - Latency: frame_tick is high in the cycle after div_cnt==FRAME_DIV-1 is observed.
  - First frame_tick after start is asserted FRAME_DIV+1 cycles after the start cycle.
- Frame events (the edge that raises frame_tick):
  - frame_cnt increments and wraps at FRAMES_PER_SEC-1. On the wrap, sec_tick is asserted in the same cycle as frame_tick.
  - spawn_cnt increments and wraps at SPAWN_FRAMES-1. On the wrap, spawn_tick is asserted in the same cycle as frame_tick.
- Timer:
  - dig0..dig3 increment as a decimal counter on the edge that raises sec_tick, so the new value is visible in the same cycle as sec_tick.
  - Carries ripple fully: 0099 -> 0100, 0999 -> 1000.
  - 9999 wraps to 0000.
- Simultaneous events:
  - A collision or pause in the same cycle that div_cnt==FRAME_DIV-1: the FSM leaves RUN, the divider holds, and no tick is issued.
  - On resume from PAUSE, the pending tick fires on the first RUN cycle.
- Ticks are never asserted outside RUN. A tick in flight is dropped if state leaves RUN.
- Reset asserted mid-game forces all reset values immediately (asynchronous); the next start begins a fresh game.
- Counter widths: ceil(log2(parameter)). The design is valid for all parameter values >= 2.

Optional Feature:
TIMER_SATURATE_EN
- Defined: the timer holds at 9999. sec_tick is still issued; the digits do not change.
- Undefined: 9999 -> 0000 wrap as above.

Decomposition:
- Package game_pkg:
  - state encodings IDLE/RUN/PAUSE/OVER;
  - state width;
  - BCD digit width (4);
  - default FRAME_DIV, FRAMES_PER_SEC, SPAWN_FRAMES.
- One sub-module, bcd4_counter:
  - inputs: clock, reset, clear, inc;
  - outputs: dig0..dig3;
  - implements the ripple carry and TIMER_SATURATE_EN.
- The FSM, divider and tick generation stay in the top module.

Test Plan:
- Bench parameters: FRAME_DIV=4, FRAMES_PER_SEC=3, SPAWN_FRAMES=5.
- 1. Reset, then start at cycle 0 -> state=RUN at cycle 1; frame_tick high at cycles 5, 9, 13, ... one cycle each; no ticks before cycle 5.
- 2. Run 15 frames -> sec_tick coincides with frames 3, 6, 9, 12, 15; spawn_tick with frames 5, 10, 15; digits read 0005 after frame 15.
- 3. Pause pulse mid-frame, hold 20 cycles, then pause again -> no ticks while PAUSE; next frame_tick spaced by the remaining divider count; digits unchanged during pause.
- 4. Collision in the same cycle as div_cnt==3 -> state=OVER next cycle; no frame_tick; digits frozen; a later start -> RUN with digits 0000.
- 5. Preload the timer to 9999 via a forced run, then one more sec_tick -> 0000 (without the macro) or 9999 held (with TIMER_SATURATE_EN).
- 6. Assert reset asynchronously mid-RUN between clock edges -> state=IDLE and all outputs 0 immediately; start, pause and collision together in IDLE -> RUN only.
